// File: rtl/datapath_raiz.sv
// ============================================================================
// datapath_raiz : restoring integer square-root datapath (WIDTH-bit radicand)
// Optional RAIZ_REMAINDER_EN adds the latched remainder port out_rem.
// Rev 1.0
// ============================================================================
`default_nettype none

module datapath_raiz #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_operand,
  input  logic                 in_RST,
  input  logic                 in_SHIFTQ,
  input  logic                 in_ADD,
  input  logic                 in_CONT,
  input  logic                 in_SHIFTR,
  input  logic                 in_DONE,
  output logic [WIDTH-1:0]     out_Q,
  output logic                 out_K,
  output logic [WIDTH/2-1:0]   out_result,
  output logic                 out_valid
`ifdef RAIZ_REMAINDER_EN
  ,
  output logic [WIDTH/2:0]     out_rem
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH/2) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH/2 - 1);

  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   a;
  logic [WIDTH/2-1:0] root;
  logic [CNT_W-1:0]   count;
  logic               done_d;
  logic [WIDTH-1:0]   trial_sub;
  logic               done_rise;

  // {root, 1} zero-extended: the root already carries the previous SHIFTR.
  assign trial_sub = {{(WIDTH/2-1){1'b0}}, root, 1'b1};
  assign out_Q     = a - trial_sub;
  assign out_K     = (count == '0);
  assign done_rise = in_DONE & ~done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x    <= '0;
      a    <= '0;
      root <= '0;
    end else if (in_RST) begin
      x    <= in_operand;
      a    <= '0;
      root <= '0;
    end else if (in_SHIFTQ) begin
      a <= {a[WIDTH-3:0], x[WIDTH-1:WIDTH-2]};
      x <= {x[WIDTH-3:0], 2'b00};
    end else if (in_ADD) begin
      a       <= out_Q;
      root[0] <= 1'b1;
    end else if (in_SHIFTR) begin
      root <= {root[WIDTH/2-2:0], 1'b0};
    end
  end

  // Counter saturates at zero so stray CONT strobes keep out_K asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= CNT_INIT;
    end else if (in_RST) begin
      count <= CNT_INIT;
    end else if (in_CONT && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_d     <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else begin
      done_d    <= in_DONE;
      out_valid <= done_rise;
      if (done_rise) begin
        out_result <= root;
      end
    end
  end

`ifdef RAIZ_REMAINDER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_rem <= '0;
    end else if (done_rise) begin
      out_rem <= a[WIDTH/2:0];
    end
  end
`endif

endmodule

`default_nettype wire
